codec_i2c_sequencer: RTL and testbench

Power-on configuration sequencer for the board's WM8731 audio codec. After reset it issues a fixed table of ten register writes over a two-wire (I2C) bus, checks every acknowledge and retries failed frames. It then holds the bus idle, optionally servicing runtime headphone-volume writes. It sits beside the audio output path, clocked from the 50 MHz board clock, and drives the codec's I2C SCLK/SDAT pins directly.

---
 rtl/codec_i2c_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_codec_i2c_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_i2c_sequencer.sv
// WM8731 power-on register sequencer over I2C, with NACK retry and sticky done/error flags.
// Define CODEC_VOLUME_EN to add runtime headphone-volume writes serviced from IDLE.
module codec_i2c_sequencer #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned I2C_FREQ   = 20000,
  parameter int unsigned POR_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  output logic       oI2C_SCLK,
  inout  wire        ioI2C_SDAT,
`ifdef CODEC_VOLUME_EN
  input  logic [6:0] iVOL,
  input  logic       iVOL_REQ,
  output logic       oVOL_ACK,
`endif
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oERR
);

  localparam int unsigned Q  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned QW = $clog2(Q);
  localparam int unsigned PW = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_POR_WAIT, S_LOAD, S_START, S_SHIFT, S_ACK, S_STOP, S_GAP, S_IDLE, S_FAIL
  } state_t;

  state_t          r_state;
  logic [QW-1:0]   r_div;
  logic [PW-1:0]   r_por;
  logic [3:0]      r_idx;
  logic [1:0]      r_ph;
  logic [2:0]      r_bit;
  logic [1:0]      r_byte;
  logic [23:0]     r_sh;
  logic [1:0]      r_retry;
  logic            r_nack;
  logic            r_scl;
  logic            r_sda_low;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            w_tick;
  logic            w_sda_in;
  logic [15:0]     w_entry;
`ifdef CODEC_VOLUME_EN
  logic            r_vol_mode;
  logic [6:0]      r_vol;
  logic            r_vol_ack;
  assign oVOL_ACK = r_vol_ack;
`endif

  assign oI2C_SCLK  = r_scl;
  assign ioI2C_SDAT = r_sda_low ? 1'b0 : 1'bz;
  assign w_sda_in   = ioI2C_SDAT;
  assign oBUSY      = r_busy;
  assign oDONE      = r_done;
  assign oERR       = r_err;
  assign w_tick     = (r_div == QW'(Q - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)     r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // {reg[6:0], data[8:0]}; R8 is left at its reset value of 0, so it is not written
  always_comb begin
    w_entry = '0;
    case (r_idx)
      4'd0:    w_entry = {7'd15, 9'h000};
      4'd1:    w_entry = {7'd0,  9'h017};
      4'd2:    w_entry = {7'd1,  9'h017};
      4'd3:    w_entry = {7'd2,  9'h179};
      4'd4:    w_entry = {7'd3,  9'h179};
      4'd5:    w_entry = {7'd4,  9'h012};
      4'd6:    w_entry = {7'd5,  9'h000};
      4'd7:    w_entry = {7'd6,  9'h000};
      4'd8:    w_entry = {7'd7,  9'h002};
      4'd9:    w_entry = {7'd9,  9'h001};
      default: w_entry = '0;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= S_POR_WAIT;
      r_por     <= '0;
      r_idx     <= '0;
      r_ph      <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_sh      <= '0;
      r_retry   <= '0;
      r_nack    <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef CODEC_VOLUME_EN
      r_vol_mode <= 1'b0;
      r_vol      <= '0;
      r_vol_ack  <= 1'b0;
`endif
    end else begin
      r_busy <= (r_state != S_IDLE) && (r_state != S_FAIL);
      if (w_tick) r_ph <= r_ph + 1'b1;
`ifdef CODEC_VOLUME_EN
      r_vol_ack <= 1'b0;
`endif
      case (r_state)
        S_POR_WAIT: begin
          if (r_por == PW'(POR_CYCLES - 1)) begin
            r_idx   <= '0;
            r_state <= S_LOAD;
          end else begin
            r_por <= r_por + 1'b1;
          end
        end
        // LOAD lasts one cycle between ticks, so back-to-back frames keep the 120*Q period
        S_LOAD: begin
`ifdef CODEC_VOLUME_EN
          if (r_vol_mode) r_sh <= {DEV_ADDR, 1'b0, 7'd2, 2'b11, r_vol};
          else            r_sh <= {DEV_ADDR, 1'b0, w_entry};
`else
          r_sh <= {DEV_ADDR, 1'b0, w_entry};
`endif
          r_ph    <= '0;
          r_nack  <= 1'b0;
          r_state <= S_START;
        end
        S_START: if (w_tick) begin
          case (r_ph)
            2'd2: r_sda_low <= 1'b1;
            2'd3: begin
              r_scl   <= 1'b0;
              r_bit   <= 3'd7;
              r_byte  <= '0;
              r_state <= S_SHIFT;
            end
            default: ;
          endcase
        end
        S_SHIFT: if (w_tick) begin
          case (r_ph)
            2'd0: r_sda_low <= ~r_sh[23];
            2'd1: r_scl <= 1'b1;
            2'd3: begin
              r_scl <= 1'b0;
              r_sh  <= {r_sh[22:0], 1'b0};
              if (r_bit == 3'd0) r_state <= S_ACK;
              else               r_bit <= r_bit - 1'b1;
            end
            default: ;
          endcase
        end
        S_ACK: if (w_tick) begin
          case (r_ph)
            2'd0: r_sda_low <= 1'b0;
            2'd1: r_scl <= 1'b1;
            2'd2: if (w_sda_in) r_nack <= 1'b1;
            default: begin
              r_scl <= 1'b0;
              if (r_nack || r_byte == 2'd2) begin
                r_state <= S_STOP;
              end else begin
                r_byte  <= r_byte + 1'b1;
                r_bit   <= 3'd7;
                r_state <= S_SHIFT;
              end
            end
          endcase
        end
        S_STOP: if (w_tick) begin
          case (r_ph)
            2'd0: r_sda_low <= 1'b1;
            2'd1: r_scl <= 1'b1;
            2'd2: r_sda_low <= 1'b0;
            default: r_state <= S_GAP;
          endcase
        end
        S_GAP: if (w_tick && r_ph == 2'd3) begin
          if (r_nack) begin
            if (r_retry == 2'(MAX_RETRY)) begin
              r_state <= S_FAIL;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_LOAD;
            end
          end else begin
            r_retry <= '0;
`ifdef CODEC_VOLUME_EN
            if (r_vol_mode) begin
              r_vol_mode <= 1'b0;
              r_vol_ack  <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else
`endif
            if (r_idx == 4'd9) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_IDLE: begin
`ifdef CODEC_VOLUME_EN
          if (iVOL_REQ) begin
            r_vol      <= iVOL;
            r_vol_mode <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
          end
`endif
        end
        S_FAIL: ;
        default: r_state <= S_POR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_i2c_sequencer.sv
// Directed bench for codec_i2c_sequencer: bus monitor/slave model with ACK policy and frame log.
// Build with CODEC_VOLUME_EN defined to also exercise the volume-write path.
module tb_codec_i2c_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic scl, busy, done, err;
  wire  sda;
  logic slave_low;
`ifdef CODEC_VOLUME_EN
  logic [6:0] vol;
  logic       vol_req;
  logic       vol_ack;
`endif

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  codec_i2c_sequencer #(
    .CLK_FREQ(400), .I2C_FREQ(20), .POR_CYCLES(10), .MAX_RETRY(3), .DEV_ADDR(7'h1A)
  ) dut (
    .iCLK(clk),
    .iRST_N(rst_n),
    .oI2C_SCLK(scl),
    .ioI2C_SDAT(sda),
`ifdef CODEC_VOLUME_EN
    .iVOL(vol),
    .iVOL_REQ(vol_req),
    .oVOL_ACK(vol_ack),
`endif
    .oBUSY(busy),
    .oDONE(done),
    .oERR(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [23:0] exp_tab [0:9] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340579, 24'h340779,
                                 24'h340812, 24'h340A00, 24'h340C00, 24'h340E02, 24'h341201};

  // slave ACK policy, set by the stimulus before each reset
  logic       nack_en = 1'b0;
  logic [3:0] nack_idx = 4'd0;
  int         nack_times = 0;

  // monitor state
  int          cyc;
  logic        prev_scl, prev_sda, prev_done, prev_busy;
  logic        in_frame, nacked;
  int          bitcnt, bytecnt, starts, glitches, nacks_given, start0_cyc, done_cyc, vol_ack_cnt;
  logic        busy_at_done, busy_pre;
  logic [7:0]  shreg;
  logic [7:0]  fbytes [0:2];
  logic [3:0]  cur_idx;
  logic [23:0] flog [0:15];
  int          attempts [0:15];

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame <= 1'b0; nacked <= 1'b0; bitcnt <= 0; bytecnt <= 0; starts <= 0;
      glitches <= 0; nacks_given <= 0; start0_cyc <= 0; done_cyc <= 0; vol_ack_cnt <= 0;
      busy_at_done <= 1'b0; busy_pre <= 1'b0; shreg <= '0; cur_idx <= '0; slave_low <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        flog[i] <= '0;
        attempts[i] <= 0;
      end
    end else begin
      if (prev_scl && scl && prev_sda && !sda) begin
        if (in_frame) glitches <= glitches + 1;
        in_frame <= 1'b1; nacked <= 1'b0; bitcnt <= 0; bytecnt <= 0;
        starts <= starts + 1;
        attempts[cur_idx] <= attempts[cur_idx] + 1;
        if (starts == 0) start0_cyc <= cyc;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        if (!in_frame || bitcnt != 1) glitches <= glitches + 1;
        in_frame <= 1'b0;
        if (bytecnt == 3 && !nacked) begin
          flog[cur_idx] <= {fbytes[0], fbytes[1], fbytes[2]};
          cur_idx <= cur_idx + 1'b1;
        end
      end else if (!prev_scl && scl && in_frame) begin
        if (bitcnt < 8) begin
          shreg  <= {shreg[6:0], sda};
          bitcnt <= bitcnt + 1;
        end else begin
          if (sda) nacked <= 1'b1;
          if (bytecnt < 3) fbytes[bytecnt] <= shreg;
          bytecnt <= bytecnt + 1;
          bitcnt  <= 0;
        end
      end else if (prev_scl && !scl && in_frame) begin
        if (bitcnt == 8 && bytecnt == 0 && nack_en && cur_idx == nack_idx &&
            nacks_given < nack_times) begin
          slave_low   <= 1'b0;
          nacks_given <= nacks_given + 1;
        end else begin
          slave_low <= (bitcnt == 8);
        end
      end
      if (done && !prev_done) begin
        done_cyc     <= cyc;
        busy_at_done <= busy;
        busy_pre     <= prev_busy;
      end
`ifdef CODEC_VOLUME_EN
      if (vol_ack) vol_ack_cnt <= vol_ack_cnt + 1;
`endif
    end
    prev_scl  <= scl;
    prev_sda  <= sda;
    prev_done <= done;
    prev_busy <= busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_table();
    for (int k = 0; k < 10; k++) check($sformatf("frame%0d_bytes", k), flog[k], exp_tab[k]);
  endtask

  initial begin
    rst_n = 1'b0;
`ifdef CODEC_VOLUME_EN
    vol = '0;
    vol_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
`ifdef CODEC_VOLUME_EN
    check("rst_vol_ack", vol_ack, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("busy_before_first_clk", busy, 1'b0);
    @(negedge clk);
    #1;
    check("busy_after_first_clk", busy, 1'b1);

    // all frames acknowledged
    wait_done(8000);
    check("A_done", done, 1'b1);
    check("A_done_time", (done_cyc >= 6010 && done_cyc <= 6016), 1'b1);
    check("A_busy_at_done", busy_at_done, 1'b0);
    check("A_busy_before_done", busy_pre, 1'b1);
    check("A_err", err, 1'b0);
    check("A_starts", starts, 10);
    check_table();
    check("A_glitches", glitches, 0);

    // address of index 3 refused twice
    nack_en = 1'b1; nack_idx = 4'd3; nack_times = 2;
    do_reset();
    wait_done(9000);
    check("B_done", done, 1'b1);
    check("B_err", err, 1'b0);
    check("B_attempts3", attempts[3], 3);
    check("B_starts", starts, 12);
    check_table();
    check("B_glitches", glitches, 0);

    // index 5 always refused
    nack_en = 1'b1; nack_idx = 4'd5; nack_times = 100;
    do_reset();
    for (int i = 0; i < 8000 && !err; i++) begin
      @(negedge clk);
      #1;
    end
    check("C_err", err, 1'b1);
    check("C_busy", busy, 1'b0);
    check("C_done", done, 1'b0);
    check("C_attempts5", attempts[5], 4);
    check("C_good_frames", cur_idx, 4'd5);
    repeat (2000) @(negedge clk);
    #1;
    check("C_starts_final", starts, 9);
    check("C_scl_idle", scl, 1'b1);
    check("C_sda_idle", sda, 1'b1);
    check("C_err_sticky", err, 1'b1);
    check("C_glitches", glitches, 0);

    // reset in the middle of index 4's register byte (0x07: fourth bit is 0)
    nack_en = 1'b0;
    do_reset();
    for (int i = 0; i < 5000 && !(cur_idx == 4'd4 && in_frame && bytecnt == 1 && bitcnt == 3); i++) begin
      @(negedge clk);
      #1;
    end
    check("D_reached_frame4", (cur_idx == 4'd4 && in_frame && bytecnt == 1 && bitcnt == 3), 1'b1);
    check("D_sda_before_rst", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    check("D_scl_in_rst", scl, 1'b1);
    check("D_sda_in_rst", sda, 1'b1);
    check("D_busy_in_rst", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100 && starts == 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("D_first_start_time", (start0_cyc >= 21 && start0_cyc <= 26), 1'b1);
    for (int i = 0; i < 1000 && cur_idx == 4'd0; i++) begin
      @(negedge clk);
      #1;
    end
    check("D_restart_frame0", flog[0], 24'h341E00);
    wait_done(8000);
    check("D_done", done, 1'b1);
    check("D_glitches", glitches, 0);

`ifdef CODEC_VOLUME_EN
    // volume request raised during index 2, serviced only after the table
    do_reset();
    for (int i = 0; i < 3000 && !(cur_idx == 4'd2 && in_frame); i++) begin
      @(negedge clk);
      #1;
    end
    vol = 7'h50;
    vol_req = 1'b1;
    wait_done(8000);
    check("E_done", done, 1'b1);
    check("E_starts_at_done", starts, 10);
    check_table();
    for (int i = 0; i < 200 && starts < 11; i++) begin
      @(negedge clk);
      #1;
    end
    check("E_busy_vol_frame", busy, 1'b1);
    for (int i = 0; i < 1500 && vol_ack_cnt == 0; i++) begin
      @(negedge clk);
      #1;
    end
    vol_req = 1'b0;
    repeat (1000) @(negedge clk);
    #1;
    check("E_vol_ack_pulses", vol_ack_cnt, 1);
    check("E_vol_bytes", flog[10], 24'h3405D0);
    check("E_starts_final", starts, 11);
    check("E_busy_idle", busy, 1'b0);
    check("E_done_sticky", done, 1'b1);
    check("E_err", err, 1'b0);
    check("E_glitches", glitches, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
